game_timebase: RTL and testbench

//  Timing responder for the reaction-game controller. It consumes the controller's ms_en/ms_rst and rand_en/rand_rst

---
 rtl/game_pkg.sv | 13 +
 rtl/ms_prescaler.sv | 26 ++
 rtl/game_timebase.sv | 103 ++++++++++
 tb/tb_game_timebase.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the reaction-game controller and its timebase
package game_pkg;
    typedef enum logic [2:0] {
        INIT    = 3'd0,
        WAIT    = 3'd1,
        GAME    = 3'd2,
        ON_TIME = 3'd3,
        LATE    = 3'd4,
        EARLY   = 3'd5
    } game_state_e;
    typedef enum logic [1:0] {R_IDLE, R_COUNT, R_DONE} rand_state_e;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/ms_prescaler.sv
// ms_prescaler: counts 0..TICKS_PER_MS-1 while enabled and flags the wrap cycle
//  clk, rst_n : clock, async active-low reset
//  en         : advance the count
//  clr        : synchronous clear, wins over en
//  wrap       : high in the cycle whose edge wraps the count back to 0
module ms_prescaler #(
    parameter int TICKS_PER_MS = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);
    localparam int W = TICKS_PER_MS > 1 ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS_PER_MS - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        wrap  = en && !clr && cnt_q == LAST;
        cnt_d = clr ? '0 : !en ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/game_timebase.sv
// game_timebase: elapsed-ms counter and LFSR-seeded random-delay timer for the reaction game
//  clk, rst_n        : clock, async active-low reset
//  ms_en, ms_rst     : run / clear the millisecond counter (clear wins)
//  rand_en, rand_rst : arm-run / abort the random delay (abort wins)
//  ms_passed         : saturating elapsed ms; ms_tick pulses with each increment
//  rand_tick         : one-cycle pulse in the cycle whose edge completes the delay
//  rand_busy         : delay in progress
module game_timebase
    import game_pkg::*;
#(
    parameter int          TICKS_PER_MS = 100_000,
    parameter int          MS_W         = 32,
    parameter int          RAND_MIN_MS  = 1000,
    parameter int          RAND_BITS    = 12,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ms_en,
    input  logic            ms_rst,
    input  logic            rand_en,
    input  logic            rand_rst,
    output logic [MS_W-1:0] ms_passed,
    output logic            ms_tick,
    output logic            rand_tick,
    output logic            rand_busy
);
    if (RAND_MIN_MS + 2**RAND_BITS - 1 >= 2**16 || TICKS_PER_MS < 1) begin : g_param_err
        $error("game_timebase: random target must fit 16 bits and TICKS_PER_MS >= 1");
    end
    logic            ms_wrap, ms_sat, ms_tick_q, ms_tick_d, r_wrap;
    logic [MS_W-1:0] ms_q, ms_d;
    logic [15:0]     lfsr_q, lfsr_d, target_q, target_d, rand_ms_q, rand_ms_d;
    rand_state_e     rstate_q, rstate_d;
    ms_prescaler #(.TICKS_PER_MS(TICKS_PER_MS)) u_ms_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ms_en),
        .clr   (ms_rst),
        .wrap  (ms_wrap)
    );
    // Rand prescaler is held clear outside R_COUNT so every arm starts a full ms period.
    ms_prescaler #(.TICKS_PER_MS(TICKS_PER_MS)) u_rand_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rstate_q == R_COUNT && rand_en),
        .clr   (rand_rst || rstate_q != R_COUNT),
        .wrap  (r_wrap)
    );
    always_comb begin
        ms_sat    = &ms_q;
        ms_tick_d = ms_wrap && !ms_sat;
        ms_d      = ms_rst ? '0 : ms_tick_d ? ms_q + 1'b1 : ms_q;
        // Galois step; a zero state would lock up, so it reloads the seed.
        lfsr_d    = lfsr_q == '0 ? LFSR_SEED : (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
    end
    always_comb begin
        rstate_d  = rstate_q;
        target_d  = target_q;
        rand_ms_d = rand_ms_q;
        rand_tick = 1'b0;
        if (rand_rst) begin
            rstate_d  = R_IDLE;
            rand_ms_d = '0;
        end else begin
            case (rstate_q)
                R_IDLE: if (rand_en) begin
                    target_d  = 16'(RAND_MIN_MS) + 16'(lfsr_q[RAND_BITS-1:0]);
                    rand_ms_d = '0;
                    rstate_d  = R_COUNT;
                end
                R_COUNT: if (r_wrap) begin
                    rand_ms_d = rand_ms_q + 16'd1;
                    if (rand_ms_q + 16'd1 == target_q) begin
                        rand_tick = 1'b1;
                        rstate_d  = R_DONE;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_q      <= '0;
            ms_tick_q <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            target_q  <= '0;
            rand_ms_q <= '0;
            rstate_q  <= R_IDLE;
        end else begin
            ms_q      <= ms_d;
            ms_tick_q <= ms_tick_d;
            lfsr_q    <= lfsr_d;
            target_q  <= target_d;
            rand_ms_q <= rand_ms_d;
            rstate_q  <= rstate_d;
        end
    end
    assign ms_passed = ms_q;
    assign ms_tick   = ms_tick_q;
    assign rand_busy = rstate_q == R_COUNT;
endmodule

// File: tb/tb_game_timebase.sv
// tb_game_timebase: randomized and directed checks of game_timebase against a behavioural model
module tb_game_timebase;
    localparam int          T    = 4;
    localparam int          MW   = 4;
    localparam int          MIN  = 2;
    localparam int          RB   = 3;
    localparam logic [15:0] SEED = 16'hACE1;
    logic clk = 1'b0, rst_n = 1'b0, ms_en = 1'b0, ms_rst = 1'b0, rand_en = 1'b0, rand_rst = 1'b0;
    logic [MW-1:0] ms_passed;
    logic ms_tick, rand_tick, rand_busy;
    int n_pass = 0, n_chk = 0;
    int m_e, m_ph, m_tgt, m_n;
    bit m_mst;
    logic [15:0] m_lfsr;
    always #5 clk = ~clk;
    game_timebase #(
        .TICKS_PER_MS (T),
        .MS_W         (MW),
        .RAND_MIN_MS  (MIN),
        .RAND_BITS    (RB),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ms_en     (ms_en),
        .ms_rst    (ms_rst),
        .rand_en   (rand_en),
        .rand_rst  (rand_rst),
        .ms_passed (ms_passed),
        .ms_tick   (ms_tick),
        .rand_tick (rand_tick),
        .rand_busy (rand_busy)
    );
    function automatic logic [15:0] galois(input logic [15:0] v);
        if (v == 16'h0) return SEED;
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0);
    endfunction
    // ms_passed is simply enabled edges since clear divided by T, capped at all-ones.
    function automatic int exp_ms();
        return m_e / T > 15 ? 15 : m_e / T;
    endfunction
    // Delay completes on the edge that brings enabled counting cycles to target*T.
    function automatic bit exp_rtick();
        return m_ph == 1 && rand_en && !rand_rst && m_n + 1 == m_tgt * T;
    endfunction
    function automatic logic [MW+2:0] exp_vec();
        return {MW'(exp_ms()), m_mst, exp_rtick(), m_ph == 1};
    endfunction
    task automatic model_reset();
        m_e = 0; m_mst = 0; m_lfsr = SEED; m_ph = 0; m_tgt = 0; m_n = 0;
    endtask
    task automatic cyc();
        @(posedge clk);
        m_mst = 0;
        if (ms_rst) m_e = 0;
        else if (ms_en) begin
            m_e   = m_e < 1000 ? m_e + 1 : m_e;
            m_mst = (m_e % T == 0) && (m_e / T <= 15);
        end
        if (rand_rst) m_ph = 0;
        else if (m_ph == 0 && rand_en) begin
            m_tgt = MIN + int'(m_lfsr[RB-1:0]);
            m_n   = 0;
            m_ph  = 1;
        end else if (m_ph == 1 && rand_en) begin
            m_n++;
            if (m_n == m_tgt * T) m_ph = 2;
        end
        m_lfsr = galois(m_lfsr);
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst_n = 1'b0; ms_en = 1'b0; ms_rst = 1'b0; rand_en = 1'b0; rand_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            {ms_en, ms_rst, rand_en, rand_rst} = 4'($urandom);
            @(negedge clk);
            n_chk++;
            if ({ms_passed, ms_tick, rand_tick, rand_busy} !== '0)
                $display("FAIL reset_hold %0d: got %h want 0", i, {ms_passed, ms_tick, rand_tick, rand_busy});
            else n_pass++;
        end
        {ms_en, ms_rst, rand_en, rand_rst} = 4'b0;
        model_reset();
        rst_n = 1'b1;
        cyc();
        n_chk++;
        if ({ms_passed, ms_tick, rand_tick, rand_busy} !== '0)
            $display("FAIL reset_release: got %h want 0", {ms_passed, ms_tick, rand_tick, rand_busy});
        else n_pass++;
    endtask
    task automatic test_ms_count();
        int ticks = 0;
        ms_rst = 1'b1;
        cyc();
        ms_rst = 1'b0; ms_en = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            cyc();
            ticks += int'(ms_tick);
            n_chk++;
            if ({ms_passed, ms_tick, rand_tick, rand_busy} !== exp_vec())
                $display("FAIL ms_run edge %0d: got %h want %h", i, {ms_passed, ms_tick, rand_tick, rand_busy}, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (ms_passed !== 4'd6 || ticks != 6) $display("FAIL ms_24_edges: got ms=%0d ticks=%0d want ms=6 ticks=6", ms_passed, ticks);
        else n_pass++;
        ms_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_chk++;
            if (ms_passed !== 4'd6 || ms_tick !== 1'b0) $display("FAIL ms_freeze %0d: got ms=%0d tick=%b want 6/0", i, ms_passed, ms_tick);
            else n_pass++;
        end
        ms_rst = 1'b1;
        cyc();
        n_chk++;
        if (ms_passed !== 4'd0) $display("FAIL ms_clear: got %0d want 0", ms_passed);
        else n_pass++;
    endtask
    task automatic test_ms_saturate();
        int ticks = 0;
        ms_rst = 1'b0; ms_en = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            cyc();
            ticks += int'(ms_tick);
            n_chk++;
            if ({ms_passed, ms_tick, rand_tick, rand_busy} !== exp_vec())
                $display("FAIL ms_sat edge %0d: got %h want %h", i, {ms_passed, ms_tick, rand_tick, rand_busy}, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (ms_passed !== 4'd15 || ticks != 15) $display("FAIL ms_saturate: got ms=%0d ticks=%0d want 15/15", ms_passed, ticks);
        else n_pass++;
        ms_en = 1'b0;
    endtask
    task automatic test_rand_basic();
        int ticks = 0, at = 0;
        do_reset();
        rand_en = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            cyc();
            if (rand_tick) begin ticks++; at = k; end
            n_chk++;
            if ({ms_passed, ms_tick, rand_tick, rand_busy} !== exp_vec())
                $display("FAIL rand_basic edge %0d: got %h want %h", k, {ms_passed, ms_tick, rand_tick, rand_busy}, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (ticks != 1 || at != 12) $display("FAIL rand_first_target: got %0d pulses at edge %0d want 1 at 12", ticks, at);
        else n_pass++;
    endtask
    task automatic test_rand_abort();
        int ticks = 0, got = 0, want;
        logic [15:0] arm;
        do_reset();
        rand_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            rand_rst = k == 6;
            cyc();
            ticks += int'(rand_tick);
            n_chk++;
            if ({ms_passed, ms_tick, rand_tick, rand_busy} !== exp_vec())
                $display("FAIL rand_abort edge %0d: got %h want %h", k, {ms_passed, ms_tick, rand_tick, rand_busy}, exp_vec());
            else n_pass++;
        end
        rand_rst = 1'b0; rand_en = 1'b0;
        repeat ($urandom_range(1, 20)) begin
            cyc();
            ticks += int'(rand_tick);
        end
        n_chk++;
        if (ticks != 0 || rand_busy !== 1'b0) $display("FAIL rand_abort_quiet: got pulses=%0d busy=%b want 0/0", ticks, rand_busy);
        else n_pass++;
        rand_en = 1'b1;
        arm = m_lfsr;
        want = (MIN + int'(arm[RB-1:0])) * T;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            if (rand_tick && got == 0) got = k;
            n_chk++;
            if ({ms_passed, ms_tick, rand_tick, rand_busy} !== exp_vec())
                $display("FAIL rand_rearm edge %0d: got %h want %h", k, {ms_passed, ms_tick, rand_tick, rand_busy}, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (got != want) $display("FAIL rand_rearm_target: got pulse at edge %0d want %0d", got, want);
        else n_pass++;
    endtask
    task automatic test_rand_pause();
        int at = 0;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            rand_en = !(k >= 5 && k <= 9);
            cyc();
            if (rand_tick) at = k;
            n_chk++;
            if ({ms_passed, ms_tick, rand_tick, rand_busy} !== exp_vec())
                $display("FAIL rand_pause edge %0d: got %h want %h", k, {ms_passed, ms_tick, rand_tick, rand_busy}, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (at != 17) $display("FAIL rand_pause_delay: got pulse at edge %0d want 17", at);
        else n_pass++;
        rand_rst = 1'b1; rand_en = 1'b1;
        cyc();
        n_chk++;
        if (rand_busy !== 1'b0 || rand_tick !== 1'b0) $display("FAIL rst_beats_en: got busy=%b tick=%b want 0/0", rand_busy, rand_tick);
        else n_pass++;
        rand_rst = 1'b0;
        cyc();
        n_chk++;
        if (rand_busy !== 1'b1) $display("FAIL rearm_after_rst: got busy=%b want 1", rand_busy);
        else n_pass++;
    endtask
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ms_en    = $urandom_range(0, 3) != 0;
            ms_rst   = $urandom_range(0, 40) == 0;
            rand_en  = $urandom_range(0, 5) != 0;
            rand_rst = $urandom_range(0, 60) == 0;
            cyc();
            n_chk++;
            if ({ms_passed, ms_tick, rand_tick, rand_busy} !== exp_vec())
                $display("FAIL random cyc %0d: got %h want %h", i, {ms_passed, ms_tick, rand_tick, rand_busy}, exp_vec());
            else n_pass++;
        end
        ms_en = 1'b1; rand_en = 1'b1; rand_rst = 1'b0; ms_rst = 1'b0;
        repeat (9) cyc();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ms_passed, ms_tick, rand_tick, rand_busy} !== '0)
            $display("FAIL async_reset: got %h want 0", {ms_passed, ms_tick, rand_tick, rand_busy});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_ms_count();
        test_ms_saturate();
        test_rand_basic();
        test_rand_abort();
        test_rand_pause();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
